// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types for the carry-save stream accumulator: FSM state encodings
// and default widths used by the interface and the top level.
package csa_stream_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ACC_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out stream bundle for csa_stream_accumulator.
// Valid/ready: a beat transfers on a rising edge where valid and ready are
// both high; the source holds data stable while valid is high and ready low.
interface csa_stream_accumulator_if
  import csa_stream_accumulator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic [CNT_WIDTH-1:0] out_count;

  // Accumulator side: sinks operands, sources results.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

endinterface

// File: rtl/csa_stream_accumulator_csa_row.sv
// Width-generic 3:2 compressor row; carry is returned unshifted so the
// caller decides how to align it.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Running total kept as sum/carry vectors; one 3:2 row per accepted beat,
// one carry-propagate add when the group's last beat has been absorbed.
module csa_stream_accumulator
  import csa_stream_accumulator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  csa_stream_accumulator_if.slave  bus,
  output logic [1:0]               dbg_state
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;

  logic [ACC_WIDTH-1:0] x_ext;
  logic [ACC_WIDTH-1:0] row_sum;
  logic [ACC_WIDTH-1:0] row_carry;
  logic [ACC_WIDTH:0]   cpa;

  assign x_ext = ACC_WIDTH'(bus.in_data);

  csa_row #(.W(ACC_WIDTH)) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (x_ext),
    .sum   (row_sum),
    .carry (row_carry)
  );

  assign cpa = {1'b0, s_q} + {1'b0, c_q};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    ovf_acc_d   = ovf_acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          s_d = row_sum;
          c_d = row_carry << 1;
          // The carry bit that falls off the top is worth 2^ACC_WIDTH.
          ovf_acc_d = ovf_acc_q | row_carry[ACC_WIDTH-1];
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (bus.in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        out_sum_d   = cpa[ACC_WIDTH-1:0];
        out_ovf_d   = ovf_acc_q | cpa[ACC_WIDTH];
        out_count_d = cnt_q;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          s_d       = '0;
          c_d       = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      ovf_acc_q   <= ovf_acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_count = out_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: a CNT_WIDTH=8 and a CNT_WIDTH=2 instance
// run in lockstep off the same stimulus, checked against a scoreboard queue.
module tb_csa_stream_accumulator;
  import csa_stream_accumulator_pkg::*;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int EW = 1 + AW + CW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus  ();
  csa_stream_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(2))  bus2 ();
  logic [1:0] dbg1, dbg2;

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  csa_stream_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg1)
  );

  csa_stream_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2.slave),
    .dbg_state (dbg2)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int acc_total = 0;
  int acc_cnt   = 0;

  function automatic logic [EW-1:0] pack_exp(input int total, input int cnt);
    logic [AW-1:0] s;
    logic [CW-1:0] c8;
    logic [1:0]    c2;
    s  = AW'(total % (1 << AW));
    c8 = (cnt > 255) ? CW'(255) : CW'(cnt);
    c2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    return {(total >= (1 << AW)), s, c8, c2};
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      acc_total = 0;
      acc_cnt   = 0;
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_without_exp", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_sum",    bus.out_sum,    e[EW-2 -: AW]);
          check("out_ovf",    bus.out_ovf,    e[EW-1]);
          check("out_count",  bus.out_count,  e[CW+1 -: CW]);
          check("out_valid2", bus2.out_valid, 1);
          check("out_sum2",   bus2.out_sum,   e[EW-2 -: AW]);
          check("out_count2", bus2.out_count, e[1:0]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_total += int'(bus.in_data);
        acc_cnt++;
        if (bus.in_last) begin
          exp_q.push_back(pack_exp(acc_total, acc_cnt));
          acc_total = 0;
          acc_cnt   = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic l);
    int budget;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", budget, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_group(input int n, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) send(d, (i == n - 1));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.in_ready) && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || !bus.in_ready) check("drain_timeout", budget, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum",   bus.out_sum,   0);
    check("rst_out_ovf",   bus.out_ovf,   0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_state",     dbg1,          ST_ACCUM);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] e;
    int budget;
    int len;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_reset();

    // back-to-back 3,5,7 and output latency
    send(4'd3, 1'b0);
    send(4'd5, 1'b0);
    send(4'd7, 1'b1);
    @(negedge clk);
    check("lat_t1_state",     dbg1,          ST_RESOLVE);
    check("lat_t1_out_valid", bus.out_valid, 0);
    check("lat_t1_in_ready",  bus.in_ready,  0);
    @(negedge clk);
    check("lat_t2_out_valid", bus.out_valid, 1);
    check("lat_t2_in_ready",  bus.in_ready,  0);
    @(negedge clk);
    check("post_hs_in_ready",  bus.in_ready,  1);
    check("post_hs_out_valid", bus.out_valid, 0);
    drain();

    send(4'd9, 1'b1);
    drain();
    send_group(16, 4'd15);
    drain();
    send_group(18, 4'd15);
    drain();

    // consumer stalls for 5 cycles in HOLD
    bus.out_ready = 1'b0;
    send(4'd6, 1'b1);
    budget = 0;
    @(negedge clk);
    while (!bus.out_valid && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    if (!bus.out_valid) check("hold_wait_timeout", budget, 0);
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready",  bus.in_ready,  0);
      check("hold_out_sum",   bus.out_sum,   e[EW-2 -: AW]);
      check("hold_out_count", bus.out_count, e[CW+1 -: CW]);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    send(4'd2, 1'b0);
    send(4'd2, 1'b1);
    drain();

    // reset mid-group discards the partial total
    send(4'd4, 1'b0);
    send(4'd4, 1'b0);
    send(4'd4, 1'b0);
    do_reset();
    send(4'd1, 1'b1);
    drain();

    // narrow counter saturates at 3
    send_group(6, 4'd1);
    drain();

    // random groups with idle gaps and consumer stalls
    for (int g = 0; g < 12; g++) begin
      bus.out_ready = ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send(W'($urandom_range(0, 15)), (i == len - 1));
      end
      if (!bus.out_ready) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      drain();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
